// File: rtl/data_memory.sv
// Word-addressed data memory with a fixed LATENCY-cycle access handshake (IDLE -> BUSY -> DONE).
// Optional range checking of the upper address bits is compiled in with DATA_MEMORY_RANGE_CHECK_EN.
module data_memory #(
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        write_en,
  input  logic [31:0] address,
  input  logic [7:0]  mem_data_in  [0:3],
  output logic [7:0]  mem_data_out [0:3],
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            oob_q, oob_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH];
  logic            accept;
  logic            commit;
  logic            mem_we;
  logic            oob_in;
  logic            addr_unused;

  // Byte-offset bits never select anything; folded here so they are visibly consumed.
  assign addr_unused = ^address[1:0];

`ifdef DATA_MEMORY_RANGE_CHECK_EN
  assign oob_in = |address[31:AW+2];
`else
  assign oob_in = 1'b0;
`endif

  assign accept = req && (state_q != BUSY);
  assign commit = (state_q == BUSY) && (cnt_q == CW'(1));
  assign mem_we = commit && we_q && !oob_q;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    oob_d   = oob_q;
    err_d   = err_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = BUSY;
          cnt_d   = CW'(LATENCY);
          idx_d   = address[AW+1:2];
          we_d    = write_en;
          wdata_d = {mem_data_in[0], mem_data_in[1], mem_data_in[2], mem_data_in[3]};
          oob_d   = oob_in;
          err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (commit) begin
          state_d = DONE;
          err_d   = oob_q;
          if (!we_q && !oob_q) begin
            rdata_d = mem[idx_q];
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifndef DATA_MEMORY_RANGE_CHECK_EN
    err_d = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      oob_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      oob_q   <= oob_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; contents survive reset and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mem_data_out[i] = rdata_q[31-8*i -: 8];
    end
  end

  assign busy = (state_q == BUSY);
  assign done = (state_q == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_data_memory.sv
// Randomized scoreboard bench for data_memory: a driver predicts each access from a word-array
// model and queues it; a monitor pops and compares on every done pulse.
module tb_data_memory;

  localparam int DEPTH = 2048;
  localparam int LAT   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, write_en;
  logic [31:0] address;
  logic [7:0]  din  [0:3];
  logic [7:0]  dout [0:3];
  logic        busy, done, err;

  logic        req1, we1;
  logic [31:0] addr1;
  logic [7:0]  din1  [0:3];
  logic [7:0]  dout1 [0:3];
  logic        busy1, done1, err1;

  always #5 clk = ~clk;

  data_memory #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req(req), .write_en(write_en), .address(address),
    .mem_data_in(din), .mem_data_out(dout), .busy(busy), .done(done), .err(err)
  );

  data_memory #(.DEPTH(16), .LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req(req1), .write_en(we1), .address(addr1),
    .mem_data_in(din1), .mem_data_out(dout1), .busy(busy1), .done(done1), .err(err1)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] b [0:3]);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  typedef struct {
    int          acc;
    bit          known;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] model [int];
  logic [31:0] last_out;
  bit          last_known;

  // Monitor: every done pulse must match the oldest queued access.
  always @(negedge clk) begin
    if (reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("done_latency", cyc - mon_e.acc, LAT);
          check("busy_low_at_done", busy, 1'b0);
          if (mon_e.known) check("mem_data_out", pk(dout), mon_e.data);
          check("err", err, mon_e.err);
        end
      end else if (sb.size() > 0) begin
        check("busy_during_access", busy, 1'b1);
      end
    end
  end

  task automatic set_din(input logic [31:0] d);
    din[0] = d[31:24]; din[1] = d[23:16]; din[2] = d[15:8]; din[3] = d[7:0];
  endtask

  // Predict the outcome of an accepted access from the memory rules and queue it.
  task automatic predict(input bit we, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   idx;
    bit   oob;
    idx = int'((a >> 2) % DEPTH);
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    oob = (a >> ($clog2(DEPTH) + 2)) != 0;
`else
    oob = 1'b0;
`endif
    e.acc = cyc;
    e.err = oob;
    if (we || oob) begin
      if (we && !oob) model[idx] = d;
      e.known = last_known;
      e.data  = last_out;
    end else if (model.exists(idx)) begin
      e.known    = 1'b1;
      e.data     = model[idx];
      last_out   = model[idx];
      last_known = 1'b1;
    end else begin
      e.known    = 1'b0;
      e.data     = '0;
      last_known = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Called just after an edge at which the DUT is IDLE or DONE; returns just after the commit edge.
  task automatic issue(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input bit hold, input bit noise);
    req = 1'b1; write_en = we; address = a; set_din(d);
    @(posedge clk); #1;
    predict(we, a, d);
    for (int k = 0; k < LAT; k++) begin
      if (noise) begin
        req = 1'b1; write_en = 1'b1; address = a + 32'h4; set_din($urandom);
      end else begin
        req = hold;
      end
      @(posedge clk); #1;
    end
    if (!hold) req = 1'b0;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, a;
    int          gap;
    reset = 1'b0; req = 1'b0; write_en = 1'b0; address = '0; set_din('0);
    req1 = 1'b0; we1 = 1'b0; addr1 = '0;
    for (int i = 0; i < 4; i++) din1[i] = '0;
    last_out = '0; last_known = 1'b1;

    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_out", pk(dout), 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Write then read back one word.
    issue(1'b1, 32'h40, 32'hDEADBEEF, 1'b0, 1'b0);
    idle(1);
    issue(1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
    check("wr_rd_0x40", pk(dout), 32'hDEADBEEF);
    idle(1);

    // Continuous req alternating between two addresses.
    issue(1'b1, 32'h0, 32'hA0A1A2A3, 1'b0, 1'b0);
    issue(1'b1, 32'h4, 32'hB0B1B2B3, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, (i % 2) ? 32'h4 : 32'h0, 32'h0, i < 5, 1'b0);
    end
    idle(2);

    // Input changes and extra req during BUSY must be ignored.
    issue(1'b1, 32'h8, 32'h12345678, 1'b0, 1'b0);
    issue(1'b1, 32'hC, 32'h9ABCDEF0, 1'b0, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 1'b0, 1'b1);
    idle(3);
    issue(1'b0, 32'hC, 32'h0, 1'b0, 1'b0);
    idle(1);

    // Reset in the middle of a write aborts it.
    issue(1'b1, 32'h10, 32'h11223344, 1'b0, 1'b0);
    idle(1);
    req = 1'b1; write_en = 1'b1; address = 32'h10; set_din(32'h55667788);
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_err", err, 1'b0);
    check("abort_out", pk(dout), 32'h0);
    sb.delete();
    last_out = '0; last_known = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    issue(1'b0, 32'h10, 32'h0, 1'b0, 1'b0);
    check("abort_no_commit", pk(dout), 32'h11223344);
    idle(1);

    // Address beyond DEPTH words: wraps, or flags err when range checking is built in.
    issue(1'b1, 32'h4, 32'hCAFEF00D, 1'b0, 1'b0);
    issue(1'b1, 32'h00002004, 32'h01020304, 1'b0, 1'b0);
    issue(1'b0, 32'h4, 32'h0, 1'b0, 1'b0);
`ifdef DATA_MEMORY_RANGE_CHECK_EN
    check("range_protect", pk(dout), 32'hCAFEF00D);
`else
    check("wrap_read", pk(dout), 32'h01020304);
`endif
    idle(1);

    // Randomized traffic over a small window of words, with occasional high address bits.
    for (int i = 0; i < 150; i++) begin
      a = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = a | ($urandom << 13);
      d = $urandom;
      issue($urandom_range(0, 1) == 1, a, d, 1'b0, $urandom_range(0, 5) == 0);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
    idle(LAT + 2);
    check("scoreboard_drained", sb.size(), 0);

    // LATENCY=1 instance: write, done next edge, back-to-back read.
    d = $urandom;
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'hC;
    din1[0] = d[31:24]; din1[1] = d[23:16]; din1[2] = d[15:8]; din1[3] = d[7:0];
    @(posedge clk); #1;
    check("l1_busy_after_accept", busy1, 1'b1);
    check("l1_no_done_yet", done1, 1'b0);
    we1 = 1'b0;
    @(posedge clk); #1;
    check("l1_write_done", done1, 1'b1);
    check("l1_write_busy", busy1, 1'b0);
    check("l1_write_out_unchanged", pk(dout1), 32'h0);
    @(posedge clk); #1;
    req1 = 1'b0;
    check("l1_read_accepted", busy1, 1'b1);
    check("l1_read_no_done", done1, 1'b0);
    @(posedge clk); #1;
    check("l1_read_done", done1, 1'b1);
    check("l1_read_data", pk(dout1), d);
    check("l1_err", err1, 1'b0);
    @(posedge clk); #1;
    check("l1_done_one_cycle", done1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The module SHALL have parameter DEPTH, default 2048, meaning the number of 32-bit words stored (power of two, >= 2).
REQ-002 The module SHALL have parameter LATENCY, default 4, meaning the number of clock edges from request acceptance to completion (>= 1).
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  in  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 req  in  1  access request, sampled only while busy=0.
REQ-006 write_en  in  1  1=write, 0=read; sampled with req.
REQ-007 address  in  32  byte address; the word index SHALL be address[log2(DEPTH)+1:2]; bits [1:0] ignored.
REQ-008 mem_data_in  in  4x8 (array [0:3])  write data; lane 0 = bits 31:24 of the word, lane 3 = bits 7:0.
REQ-009 mem_data_out  out  4x8 (array [0:3])  read data, same lane order.
REQ-010 busy  out  1  access in progress.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 err  out  1  range-error flag (see Configuration).

Function
REQ-013 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-014 In IDLE or DONE with req=1 at rising edge N, the block SHALL latch address, write_en and all four data lanes, load a counter with LATENCY, enter BUSY, and set busy=1.
REQ-015 In BUSY the counter SHALL decrement each edge; address/data/req input changes SHALL have no effect.
REQ-016 At edge N+LATENCY the block SHALL commit the access, enter DONE, set busy=0 and done=1.
REQ-017 Write commit: the latched lanes SHALL be stored at the latched index; mem_data_out SHALL be unchanged.
REQ-018 Read commit: mem_data_out SHALL be loaded with the four bytes at the latched index and SHALL hold until the next read commit.
REQ-019 done SHALL be high for exactly one cycle; DONE SHALL go to IDLE at the next edge unless req=1, in which case it SHALL accept the request (back-to-back, zero idle cycles).
REQ-020 req in BUSY SHALL be ignored, not queued.
REQ-021 A read of a word never written since power-up SHALL return an undefined value; a read after a write to the same index SHALL return the written bytes.
REQ-022 Addresses beyond DEPTH words SHALL wrap modulo DEPTH (when range checking is not compiled in).

Reset
REQ-023 Asserting reset (low) SHALL immediately force state IDLE, busy=0, done=0, err=0, counter=0, and all mem_data_out lanes 8'h00.
REQ-024 Reset during BUSY SHALL abort the access; a pending write SHALL NOT be committed.
REQ-025 Reset SHALL NOT clear the storage array.
REQ-026 After reset deassertion, the first rising edge with req=1 SHALL be accepted.

Configuration
REQ-027 With DATA_MEMORY_RANGE_CHECK_EN defined, any accepted request with address[31:log2(DEPTH)+2] non-zero SHALL complete with normal timing, assert err=1 together with done, suppress the write, and leave mem_data_out unchanged; err SHALL clear on the next accepted request or reset.
REQ-028 Without DATA_MEMORY_RANGE_CHECK_EN, err SHALL be tied to 0 and addresses SHALL wrap per REQ-022.

Verification
REQ-029 Write 0x00000040 with lanes {DE,AD,BE,EF}, then read 0x00000040 -> done exactly 4 cycles after each acceptance, busy high 4 cycles, mem_data_out={DE,AD,BE,EF}.
REQ-030 Read request held with req=1 continuously, alternating addresses 0x0/0x4 -> one access accepted per 5 edges, done pulses 1 cycle wide, no dropped/duplicated commits.
REQ-031 Mid-BUSY change of address from 0x8 to 0xC with req=1 -> committed access uses 0x8; second request not queued.
REQ-032 Write 0x10 = {11,22,33,44}, then write 0x10 = {55,66,77,88} with reset pulsed low 2 cycles after acceptance -> busy/done/mem_data_out cleared immediately; subsequent read returns {11,22,33,44}.
REQ-033 DEPTH=2048, write address 0x00002004 = {01,02,03,04} -> without macro, read 0x4 returns {01,02,03,04}; with DATA_MEMORY_RANGE_CHECK_EN, err=1 with done and 0x4 unchanged.
REQ-034 LATENCY=1 -> write at edge N, done at edge N+1, back-to-back read accepted at edge N+2 returns written data.
